// File: rtl/cpu_clk_pkg.sv
// Shared encodings and defaults for the CPU clock/step controller.
package cpu_clk_pkg;

  // Operating modes selected by the board switches (2'b11 also behaves as hold)
  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_HOLD = 2'b10;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_HIGH = 2'b01;
  localparam logic [1:0] ST_LOW  = 2'b10;

  // Default configuration: half-periods in board clock cycles
  localparam int          DEF_CNT_W = 32;
  localparam int unsigned DEF_DIV0  = 32'd10000;
  localparam int unsigned DEF_DIV1  = 32'd100000;
  localparam int unsigned DEF_DIV2  = 32'd1000000;
  localparam int unsigned DEF_DIV3  = 32'd10000000;

  // A zero half-period would never terminate a phase, so it is promoted to 1
  function automatic int unsigned div_floor1(input int unsigned d);
    int unsigned r;
    if (d == 32'd0) begin
      r = 32'd1;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser followed by a rising-edge detector for an
// asynchronous level input such as a push button.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise
);

  // Depth below two gives no metastability protection, so clamp it
  localparam int L_STAGES = (STAGES < 2) ? 2 : STAGES;

  logic [L_STAGES-1:0] r_sync;
  logic                r_prev;

  // Shift the raw input through the synchroniser and remember the last synced level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {L_STAGES{1'b0}};
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[L_STAGES-2:0], i_d};
      r_prev <= r_sync[L_STAGES-1];
    end
  end

  // One-cycle pulse on a 0->1 transition of the synchronised level
  assign o_rise = r_sync[L_STAGES-1] & ~r_prev;

endmodule

// File: rtl/cpu_clk_gen.sv
// CPU clock and step controller: divides the board clock by a run-time
// selectable half-period, with run / single-step / hold modes and a count of
// generated CPU clock cycles. The active half-period is latched at the start
// of each high phase so rate changes never produce a runt or stretched pulse.
// Every DIVn must fit in CNT_W bits; larger values are a configuration error.
module cpu_clk_gen
  import cpu_clk_pkg::*;
#(
  parameter int          CNT_W       = DEF_CNT_W,
  parameter int unsigned DIV0        = DEF_DIV0,
  parameter int unsigned DIV1        = DEF_DIV1,
  parameter int unsigned DIV2        = DEF_DIV2,
  parameter int unsigned DIV3        = DEF_DIV3,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       hz_sel,
  input  logic [1:0]       mode,
  input  logic             go,
  output logic             clk_n,
  output logic             tick,
  output logic             running,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [CNT_W-1:0] L_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] L_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] L_DIV0 = CNT_W'(div_floor1(DIV0));
  localparam logic [CNT_W-1:0] L_DIV1 = CNT_W'(div_floor1(DIV1));
  localparam logic [CNT_W-1:0] L_DIV2 = CNT_W'(div_floor1(DIV2));
  localparam logic [CNT_W-1:0] L_DIV3 = CNT_W'(div_floor1(DIV3));

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic             r_clk_n;
  logic             r_tick;
  logic             r_running;
  logic [CNT_W-1:0] r_cycle;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] w_sel_div;
  logic             w_start;
  logic             w_at_end;
  logic             w_go_rise;

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_go_sync (
    .i_clk   (clk),
    .i_rst_n (clr),
    .i_d     (go),
    .o_rise  (w_go_rise)
  );

  // Rate table lookup; only consumed when a new period starts
  always_comb begin
    w_sel_div = L_DIV0;
    case (hz_sel)
      2'd0:    w_sel_div = L_DIV0;
      2'd1:    w_sel_div = L_DIV1;
      2'd2:    w_sel_div = L_DIV2;
      2'd3:    w_sel_div = L_DIV3;
      default: w_sel_div = L_DIV0;
    endcase
  end

  // Last count of the current phase, against the half-period latched for this period
  assign w_at_end = (r_cnt == (r_div - L_ONE));

  // Next-state logic: IDLE waits for run mode or an accepted step edge, HIGH and
  // LOW each last one latched half-period, and the end of LOW decides run vs stop
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = L_ZERO;
        if ((mode == MODE_RUN) || ((mode == MODE_STEP) && w_go_rise)) begin
          w_state_nxt = ST_HIGH;
          w_div_nxt   = w_sel_div;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (w_at_end) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = L_ZERO;
        end else begin
          w_cnt_nxt = r_cnt + L_ONE;
        end
      end
      ST_LOW: begin
        if (w_at_end) begin
          w_cnt_nxt = L_ZERO;
          if (mode == MODE_RUN) begin
            w_state_nxt = ST_HIGH;
            w_div_nxt   = w_sel_div;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + L_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = L_ZERO;
      end
    endcase
  end

  // State, counters and registered output decode of the next state
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state   <= ST_IDLE;
      r_cnt     <= L_ZERO;
      r_div     <= L_DIV0;
      r_clk_n   <= 1'b0;
      r_tick    <= 1'b0;
      r_running <= 1'b0;
      r_cycle   <= L_ZERO;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_div     <= w_div_nxt;
      r_clk_n   <= (w_state_nxt == ST_HIGH);
      r_tick    <= w_start;
      r_running <= (w_state_nxt != ST_IDLE);
      if (w_start) begin
        r_cycle <= r_cycle + L_ONE;
      end else begin
        r_cycle <= r_cycle;
      end
    end
  end

  assign clk_n     = r_clk_n;
  assign tick      = r_tick;
  assign running   = r_running;
  assign cycle_cnt = r_cycle;

endmodule
